speed_profile_ctrl: RTL and testbench

//  Sequences the board's rate-select datapath: owns the free-running CLK_50 prescaler and the frequency select.

---
 rtl/speed_profile_pkg.sv | 14 +
 rtl/speed_profile_ctrl_rate_tick_gen.sv | 36 +++
 rtl/speed_profile_ctrl.sv | 133 +++++++++++++
 tb/tb_speed_profile_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_profile_pkg.sv
// Shared types for the rate-select profile controller.
// State encoding doubles as the externally visible state code.
package speed_profile_pkg;

    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_CRUISE  = 2'd2,
        ST_RAMP_DN = 2'd3
    } state_t;

endpackage

// File: rtl/speed_profile_ctrl_rate_tick_gen.sv
// Free-running prescaler with a select-indexed, registered tick enable.
// The counter is never realigned, so the first period after a select change may be short.
module rate_tick_gen #(
    parameter int DIV_W    = 26,
    parameter int BASE_BIT = 25,
    parameter int SEL_W    = 3
) (
    input  logic             CLK_50,
    input  logic             reset,
    input  logic [SEL_W-1:0] freq_sel,
    output logic             tick
);

    localparam int SH_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] mask;
    logic [SH_W-1:0]  span;

    // mask covers bits [BASE_BIT-freq_sel:0]
    always_comb begin
        span = SH_W'(BASE_BIT + 1) - SH_W'(freq_sel);
        mask = ~({DIV_W{1'b1}} << span);
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            tick  <= (cnt_q & mask) == mask;
        end
    end

endmodule

// File: rtl/speed_profile_ctrl.sv
// Rate-select sequencer: manual stepping in IDLE, automatic ramp/cruise/ramp
// profile on start, early ramp-down on stop.
module speed_profile_ctrl
    import speed_profile_pkg::*;
#(
    parameter int DIV_W        = 26,
    parameter int BASE_BIT     = 25,
    parameter int MAX_SEL      = 5,
    parameter int DWELL_TICKS  = 4,
    parameter int CRUISE_TICKS = 8
) (
    input  logic       CLK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       step_up,
    input  logic       step_dn,
    output logic [2:0] freq_sel,
    output logic       tick,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    localparam int MAX_DW = (DWELL_TICKS > CRUISE_TICKS) ? DWELL_TICKS : CRUISE_TICKS;
    localparam int DW_W   = (MAX_DW > 1) ? $clog2(MAX_DW) : 1;

    localparam logic [DW_W-1:0]  DWELL_LAST  = DW_W'(DWELL_TICKS - 1);
    localparam logic [DW_W-1:0]  CRUISE_LAST = DW_W'(CRUISE_TICKS - 1);
    localparam logic [SEL_W-1:0] SEL_MAX     = SEL_W'(MAX_SEL);
    localparam logic [SEL_W-1:0] SEL_PRE     = SEL_W'(MAX_SEL - 1);

    state_t           st_q, st_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             done_q, done_d;

    rate_tick_gen #(
        .DIV_W   (DIV_W),
        .BASE_BIT(BASE_BIT),
        .SEL_W   (SEL_W)
    ) u_tick (
        .CLK_50  (CLK_50),
        .reset   (reset),
        .freq_sel(sel_q),
        .tick    (tick)
    );

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            st_q    <= ST_IDLE;
            dwell_q <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            dwell_q <= dwell_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        dwell_d = dwell_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    st_d    = ST_RAMP_UP;
                    dwell_d = '0;
                end else if (step_up && !step_dn) begin
                    if (sel_q != SEL_MAX) sel_d = sel_q + 1'b1;
                end else if (step_dn && !step_up) begin
                    if (sel_q != '0) sel_d = sel_q - 1'b1;
                end
            end
            ST_RAMP_UP: begin
                if (stop) begin
                    st_d    = ST_RAMP_DN;
                    dwell_d = '0;
                end else if (sel_q == SEL_MAX) begin
                    st_d    = ST_CRUISE;
                    dwell_d = '0;
                end else if (tick) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        sel_d   = sel_q + 1'b1;
                        if (sel_q == SEL_PRE) st_d = ST_CRUISE;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            ST_CRUISE: begin
                if (stop) begin
                    st_d    = ST_RAMP_DN;
                    dwell_d = '0;
                end else if (tick) begin
                    if (dwell_q == CRUISE_LAST) begin
                        dwell_d = '0;
                        st_d    = ST_RAMP_DN;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            ST_RAMP_DN: begin
                if (tick) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        if (sel_q == '0) begin
                            st_d   = ST_IDLE;
                            done_d = 1'b1;
                        end else begin
                            sel_d = sel_q - 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    assign freq_sel = sel_q;
    assign busy     = (st_q != ST_IDLE);
    assign done     = done_q;
    assign state    = st_q;

endmodule

// File: tb/tb_speed_profile_ctrl.sv
// Scoreboard bench for speed_profile_ctrl: output-change events and tick
// gaps are queued by the stimulus and checked by an independent monitor.
module tb_speed_profile_ctrl;

    logic       CLK_50  = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       step_up = 1'b0;
    logic       step_dn = 1'b0;
    logic [2:0] freq_sel;
    logic       tick;
    logic       busy;
    logic       done;
    logic [1:0] state;

    speed_profile_ctrl #(
        .DIV_W       (6),
        .BASE_BIT    (4),
        .MAX_SEL     (3),
        .DWELL_TICKS (2),
        .CRUISE_TICKS(3)
    ) dut (
        .CLK_50  (CLK_50),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .step_up (step_up),
        .step_dn (step_dn),
        .freq_sel(freq_sel),
        .tick    (tick),
        .busy    (busy),
        .done    (done),
        .state   (state)
    );

    always #10 CLK_50 = ~CLK_50;

    typedef struct {
        int st;
        int sel;
        int dn;
        int nt;
    } ev_t;

    ev_t sb_q[$];
    int  tq[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // nt = ticks consumed since previous event; -1 when not tick-driven
    task automatic ev(input int st, input int sel, input int dn, input int nt);
        ev_t e;
        e.st  = st;
        e.sel = sel;
        e.dn  = dn;
        e.nt  = nt;
        sb_q.push_back(e);
    endtask

    task automatic push_profile(input bit early_stop);
        ev(1, 0, 0, -1);
        ev(1, 1, 0, 2);
        ev(1, 2, 0, 2);
        ev(2, 3, 0, 2);
        if (early_stop) ev(3, 3, 0, -1);
        else            ev(3, 3, 0, 3);
        ev(3, 2, 0, 2);
        ev(3, 1, 0, 2);
        ev(3, 0, 0, 2);
        ev(0, 0, 1, 2);
        ev(0, 0, 0, -1);
    endtask

    // monitor
    logic [6:0] cur, prev;
    int cyc, last_tk, ntk;
    always @(negedge CLK_50) begin
        cur = {state, freq_sel, busy, done};
        if (reset) begin
            prev    = cur;
            cyc     = 0;
            last_tk = 0;
            ntk     = 0;
        end else begin
            cyc++;
            if (cur != prev) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event", {25'd0, cur}, {25'd0, prev});
                end else begin
                    ev_t e;
                    e = sb_q.pop_front();
                    chk("ev_state", int'(state), e.st);
                    chk("ev_sel", int'(freq_sel), e.sel);
                    chk("ev_busy", int'(busy), int'(e.st != 0));
                    chk("ev_done", int'(done), e.dn);
                    if (e.nt >= 0) chk("ev_ticks", ntk, e.nt);
                end
                ntk = 0;
            end
            prev = cur;
            if (tick) begin
                ntk++;
                if (tq.size() != 0) chk("tick_gap", cyc - last_tk, tq.pop_front());
                last_tk = cyc;
            end
        end
    end

    task automatic pulse(input logic s, input logic p, input logic u, input logic d);
        @(negedge CLK_50);
        #1 {start, stop, step_up, step_dn} = {s, p, u, d};
        @(negedge CLK_50);
        #1 {start, stop, step_up, step_dn} = 4'b0000;
    endtask

    task automatic drain_sb(input string nm, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge CLK_50);
            n++;
        end
        chk({nm, "_events_left"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic drain_tq(input string nm, input int budget);
        int n = 0;
        while (tq.size() != 0 && n < budget) begin
            @(negedge CLK_50);
            n++;
        end
        chk({nm, "_ticks_left"}, tq.size(), 0);
        tq.delete();
    endtask

    task automatic wait_cond(input string nm, input int st, input int sel, input int budget);
        int n = 0;
        while (!(state == 2'(st) && (sel < 0 || freq_sel == 3'(sel))) && n < budget) begin
            @(negedge CLK_50);
            n++;
        end
        chk({nm, "_reached"}, int'(n < budget), 1);
    endtask

    task automatic wait_tick(input int budget);
        int n = 0;
        @(negedge CLK_50);
        while (!tick && n < budget) begin
            @(negedge CLK_50);
            n++;
        end
        chk("tick_seen", int'(tick), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset state and post-reset tick timing at sel=0
        #15;
        chk("rst_sel", int'(freq_sel), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_state", int'(state), 0);
        repeat (2) @(negedge CLK_50);
        tq.push_back(32); tq.push_back(32); tq.push_back(32);
        #2 reset = 1'b0;
        drain_tq("rst_timing", 120);

        // manual stepping
        ev(0, 1, 0, -1); ev(0, 2, 0, -1); ev(0, 3, 0, -1);
        repeat (4) pulse(0, 0, 1, 0);
        drain_sb("step_up", 10);
        chk("sat_max", int'(freq_sel), 3);
        wait_tick(20);
        @(negedge CLK_50);
        tq.push_back(4); tq.push_back(4); tq.push_back(4);
        drain_tq("sel3_period", 30);
        ev(0, 2, 0, -1); ev(0, 1, 0, -1);
        repeat (2) pulse(0, 0, 0, 1);
        drain_sb("step_dn", 10);
        pulse(0, 0, 1, 1);
        repeat (3) @(negedge CLK_50);
        chk("both_steps", int'(freq_sel), 1);
        ev(0, 0, 0, -1);
        repeat (2) pulse(0, 0, 0, 1);
        drain_sb("step_dn_sat", 10);
        chk("sat_zero", int'(freq_sel), 0);

        // full profile
        push_profile(1'b0);
        pulse(1, 0, 0, 0);
        drain_sb("profile", 2000);

        // stop during cruise
        push_profile(1'b1);
        pulse(1, 0, 0, 0);
        wait_cond("cruise", 2, 3, 1000);
        pulse(0, 1, 0, 0);
        drain_sb("stop_cruise", 2000);

        // start+stop together in idle
        pulse(1, 1, 0, 0);
        repeat (5) @(negedge CLK_50);
        chk("start_stop_idle", int'(state), 0);
        chk("start_stop_busy", int'(busy), 0);

        // start/step during ramp-up ignored
        push_profile(1'b0);
        pulse(1, 0, 0, 0);
        repeat (3) @(negedge CLK_50);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        drain_sb("busy_ignore", 2000);

        // asynchronous reset mid ramp-up
        push_profile(1'b0);
        pulse(1, 0, 0, 0);
        wait_cond("ramp_sel2", 1, 2, 1000);
        @(negedge CLK_50);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_sel", int'(freq_sel), 0);
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_tick", int'(tick), 0);
        sb_q.delete();
        tq.delete();
        repeat (3) @(negedge CLK_50);
        tq.push_back(32); tq.push_back(32);
        #2 reset = 1'b0;
        drain_tq("rst2_timing", 100);
        chk("final_events_left", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
